sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's 8-bit FIFO, generalised in data width and depth.
- Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count and a synchronous flush.
- Adds sticky overflow/underflow error flags and a first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer datapaths in the verification-target designs and is driven/monitored by the existing fifo_if-style UVM agents.

Parameters:
- DATA_WIDTH, 8, width of din/dout.
- DEPTH, 16, number of entries; power of two, >= 4.
- FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through.
- CNT_W, $clog2(DEPTH)+1, width of count and threshold ports (derived; not overridden).

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset, asserted async, deasserted sync to clk externally.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read/pop request.
- dout  out  DATA_WIDTH  read data.
- af_thresh  in  CNT_W  almost_full threshold.
- ae_thresh  in  CNT_W  almost_empty threshold.
- clr_err  in  1  synchronous clear of sticky error flags.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- count  out  CNT_W  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (rst_n=0, async):
  - wr_ptr, rd_ptr and count are 0.
  - dout is 0, overflow and underflow are 0.
  - empty is 1, full is 0, almost_empty is 1.
  - almost_full is (af_thresh==0).
  - Storage contents are not reset.
- Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate register.
- Acceptance uses the current-cycle registered flags only:
  - A write is accepted iff wr_en && !full.
  - A read is accepted iff rd_en && !empty.
- Simultaneous accepted write and read: count is unchanged and both pointers advance.
- Full with wr_en && rd_en: only the read is accepted, count decrements, overflow is set.
- Empty with wr_en && rd_en: only the write is accepted, count increments, underflow is set.
- full and empty are decoded from the count register.
- almost_full and almost_empty are combinational compares of the count register against the threshold ports. There is no combinational path from wr_en/rd_en to any output.
- Standard mode (FWFT=0):
  - Accepted read at edge N: dout = entry[rd_ptr] after edge N (1-cycle latency).
  - Otherwise dout holds its last value, including across flush.
- FWFT mode (FWFT=1):
  - dout = entry[rd_ptr] whenever !empty. rd_en pops and the next entry appears after the edge.
  - dout = 0 while empty.
  - The first write into an empty FIFO is visible on dout the cycle after the write edge.
- Error flags:
  - overflow is set on wr_en && full; underflow is set on rd_en && empty.
  - They are cleared only by clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the flag is set (error wins).
- flush (synchronous):
  - Pointers and count go to 0.
  - It has priority over wr_en and rd_en in the same cycle; those requests are discarded and do not set error flags.
  - Error flags are unaffected by flush.
- Threshold ports may change at any time; the flags follow combinationally. Thresholds greater than DEPTH make almost_full permanently 0.
- Reset mid-operation: all state returns to reset values immediately; contents are lost logically (empty=1).

Decomposition:
- fifo_pkg holds:
  - function clog2-based width helpers;
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT};
  - DEPTH legality check constants.
- One sub-module, fifo_mem:
  - DEPTH x DATA_WIDTH storage array;
  - one synchronous write port and one asynchronous read port indexed by rd_ptr.
- sync_fifo_prog instantiates fifo_mem and contains the pointer, count, flag, error and dout logic.
- Elaboration-time assertion: DEPTH is a power of two and >= 4.

Test Plan (DATA_WIDTH=8, DEPTH=16):
- Reset, then write 0x01..0x10 (16 writes), FWFT=0:
  - count reaches 16, full=1;
  - almost_full=1 from count 14 with af_thresh=14;
  - reads return 0x01..0x10 in order, each one cycle after its rd_en;
  - ends with empty=1, count=0.
- Fill to 16, then a 17th write of 0xAA:
  - dropped, overflow=1, count stays 16;
  - a later clr_err pulse gives overflow=0.
- Empty FIFO, rd_en for 1 cycle:
  - underflow=1 and dout unchanged;
  - clr_err together with another rd_en leaves underflow=1.
- Full FIFO with wr_en=rd_en=1 for 1 cycle:
  - read only, count=15, overflow=1.
- Empty FIFO with wr_en=rd_en=1:
  - write only, count=1, underflow=1.
- FWFT=1:
  - write 0x5A into empty FIFO, and dout=0x5A the next cycle with no rd_en;
  - pop, and dout=0 with empty=1.
- Mid-stream checks:
  - write 5 entries then flush together with wr_en: count=0, empty=1, no error flags.
  - with 8 entries, assert rst_n=0 asynchronously between edges: count=0, dout=0 immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO: read-mode enum,
// width helpers and the depth legality rule checked at elaboration.
package fifo_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Smallest depth that keeps the almost-full/almost-empty flags meaningful
   localparam int MIN_DEPTH = 4;

   // Pointer width: pointers wrap naturally because DEPTH is a power of two
   function automatic int addr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Occupancy width: one extra bit so that count can reach DEPTH itself
   function automatic int cnt_width(input int depth);
      return addr_width(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   function automatic bit depth_legal(input int depth);
      return is_pow2(depth) && (depth >= MIN_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, synchronous write port and an
// asynchronous read port so the top can offer first-word-fall-through.
// Contents are deliberately not reset; validity is tracked by the pointers.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = addr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: store accepted data at the write pointer
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous flush, sticky overflow/underflow flags and an
// optional first-word-fall-through read mode. All flags are decoded from
// registered state only, so no request input reaches an output combinationally.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter int  DEPTH      = 16,
   parameter int  FWFT       = 0,
   localparam int CNT_W      = cnt_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic [CNT_W-1:0]      af_thresh,
   input  logic [CNT_W-1:0]      ae_thresh,
   input  logic                  clr_err,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int         ADDR_W = addr_width(DEPTH);
   localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   if (!depth_legal(DEPTH)) begin : g_depth_check
      $error("sync_fifo_prog: DEPTH must be a power of two and at least 4");
   end

   logic [ADDR_W-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]      count_reg, count_next;
   logic                  overflow_reg, overflow_next;
   logic                  underflow_reg, underflow_next;
   logic                  is_full, is_empty;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   assign is_full  = (count_reg == CNT_W'(DEPTH));
   assign is_empty = (count_reg == '0);

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_reg),
      .wr_data (din),
      .rd_addr (rd_ptr_reg),
      .rd_data (mem_rd_data)
   );

   // Next-state: acceptance from registered flags, flush overrides requests,
   // error flags are sticky and a new error beats clr_err in the same cycle
   always_comb begin
      wr_acc         = wr_en && !is_full && !flush;
      rd_acc         = rd_en && !is_empty && !flush;
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      overflow_next  = (!flush && wr_en && is_full)  || (overflow_reg  && !clr_err);
      underflow_next = (!flush && rd_en && is_empty) || (underflow_reg && !clr_err);

      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // State registers for pointers, occupancy and sticky error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Head entry is presented directly; zero while nothing is stored
      assign dout = is_empty ? '0 : mem_rd_data;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_reg;

      // Capture the head entry on an accepted read; hold otherwise (also across flush)
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_reg <= '0;
         end else if (rd_acc) begin
            dout_reg <= mem_rd_data;
         end
      end

      assign dout = dout_reg;
   end

   assign full         = is_full;
   assign empty        = is_empty;
   assign almost_full  = (count_reg >= af_thresh);
   assign almost_empty = (count_reg <= ae_thresh);
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one standard-mode and one FWFT-mode instance share
// the same stimulus and are compared every cycle against a queue-based model.
module tb_sync_fifo_prog;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n, flush, wr_en, rd_en, clr_err;
   logic [DW-1:0] din;
   logic [CW-1:0] af_thresh, ae_thresh;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [CW-1:0] s_count, f_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: contents as a queue, standard-mode output register, flags
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout;
   bit            m_ovf, m_unf;

   always #5 clk = ~clk;

   sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(s_dout), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clr_err(clr_err), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(f_dout), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clr_err(clr_err), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      int            n;
      logic [DW-1:0] head;
      n    = mq.size();
      head = (n > 0) ? mq[0] : '0;
      check_value("s_count", 32'(s_count), 32'(n));
      check_value("f_count", 32'(f_count), 32'(n));
      check_value("s_full",  32'(s_full),  32'(n == DEPTH));
      check_value("f_full",  32'(f_full),  32'(n == DEPTH));
      check_value("s_empty", 32'(s_empty), 32'(n == 0));
      check_value("f_empty", 32'(f_empty), 32'(n == 0));
      check_value("s_af",    32'(s_af),    32'(n >= int'(af_thresh)));
      check_value("f_af",    32'(f_af),    32'(n >= int'(af_thresh)));
      check_value("s_ae",    32'(s_ae),    32'(n <= int'(ae_thresh)));
      check_value("f_ae",    32'(f_ae),    32'(n <= int'(ae_thresh)));
      check_value("s_ovf",   32'(s_ovf),   32'(m_ovf));
      check_value("f_ovf",   32'(f_ovf),   32'(m_ovf));
      check_value("s_unf",   32'(s_unf),   32'(m_unf));
      check_value("f_unf",   32'(f_unf),   32'(m_unf));
      check_value("s_dout",  32'(s_dout),  32'(m_dout));
      check_value("f_dout",  32'(f_dout),  32'(head));
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   // Apply one clock of requests, advance the model by the FIFO rules, then check
   task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit f, input bit c);
      bit was_full, was_empty;
      wr_en   = w;
      din     = d;
      rd_en   = r;
      flush   = f;
      clr_err = c;
      @(posedge clk);
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (f) begin
         mq.delete();
         m_ovf = m_ovf && !c;
         m_unf = m_unf && !c;
      end else begin
         m_ovf = (w && was_full)  || (m_ovf && !c);
         m_unf = (r && was_empty) || (m_unf && !c);
         if (r && !was_empty) m_dout = mq.pop_front();
         if (w && !was_full)  mq.push_back(d);
      end
      #1;
      cyc++;
      check_all();
      $display("cyc %0d wr=%0d din=%02h rd=%0d flush=%0d clr=%0d -> count=%0d s_dout=%02h f_dout=%02h ovf=%0d unf=%0d",
               cyc, w, d, r, f, c, s_count, s_dout, f_dout, s_ovf, s_unf);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Reset asserted between clock edges; outputs must clear without an edge
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      $display("async reset asserted -> count=%0d s_dout=%02h f_dout=%02h", s_count, s_dout, f_dout);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      clr_err   = 1'b0;
      din       = '0;
      af_thresh = '0;
      ae_thresh = '0;
      model_reset();

      // Reset state, with af_thresh=0 so almost_full must read 1
      repeat (2) @(posedge clk);
      #1;
      check_all();
      af_thresh = CW'(14);
      ae_thresh = CW'(2);
      #1;
      check_all();
      #5;
      rst_n = 1'b1;

      // Fill with 0x01..0x10, then an overflowing 0xAA, then clear the flag
      for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Drain in order
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Underflow, then clr_err together with another bad read keeps it set
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Full with simultaneous write and read: read only, overflow set
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Empty with simultaneous write and read: write only, underflow set
      for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // First-word-fall-through: 0x5A visible without a read, then popped
      cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      idle();
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Five writes, then flush together with a write: no errors, empty
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
      idle();

      // Eight entries and one read, then asynchronous reset between edges
      for (int i = 0; i < 8; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      async_reset();
      idle();

      // Randomised traffic with drifting write/read bias and changing thresholds
      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = ((i / 100) % 2 == 0) ? 70 : 30;
         if (i % 50 == 0) begin
            af_thresh = CW'($urandom_range(0, 20));
            ae_thresh = CW'($urandom_range(0, 20));
            #1;
            check_all();
         end
         cycle(($urandom_range(0, 99) < wp), DW'($urandom),
               ($urandom_range(0, 99) < (100 - wp)),
               ($urandom_range(0, 99) < 2),
               ($urandom_range(0, 99) < 5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
